// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU pipeline types: the machine word, the fetch-stage state encoding,
// and the default instruction encodings the fetch stage treats specially.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // normal fetch from pc_addr
        DRAIN = 2'd1,   // waiting out a cache miss squashed by a flush
        HALT  = 2'd2    // fetch stopped on a halt instruction
    } fetch_state_t;

    localparam word_t HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam word_t NOP_WORD_DEFAULT  = 32'h0000_0000;

    localparam word_t INSTR_BYTES = 32'd4;

endpackage : cpu_types_pkg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage between the program counter and the IF/ID latch.
// Issues instruction-cache reads, tells the PC when to hold, captures fetched
// instructions into IF/ID, and handles downstream stall/flush and halt.
//
// Ports:
//   CLK         rising-edge clock
//   nRST        asynchronous active-low reset
//   pc_addr     current PC value
//   pc_wait     1 = PC must hold its value this cycle
//   imemREN     instruction-cache read enable
//   imemaddr    instruction-cache read address
//   ihit        instruction-cache data valid this cycle
//   imemload    instruction-cache read data
//   stall       hold IF/ID, do not advance
//   flush       squash the fetch (taken branch/jump resolved)
//   ifid_instr  latched instruction
//   ifid_npc    latched pc_addr + 4
//   ifid_valid  IF/ID holds a real instruction
//   halted      fetch has stopped on HALT_WORD
// -----------------------------------------------------------------------------
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t HALT_WORD = HALT_WORD_DEFAULT,
    parameter word_t NOP_WORD  = NOP_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_addr,
    output logic        pc_wait,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    word_t        drain_addr_q, drain_addr_d;
    word_t        ifid_instr_q, ifid_instr_d;
    word_t        ifid_npc_q, ifid_npc_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic         req_en;
    word_t        req_addr;
    logic         hold_pc;

    // Next-state and IF/ID update. Priority within a cycle is flush > stall > ihit.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        drain_addr_d = drain_addr_q;
        ifid_instr_d = ifid_instr_q;
        ifid_npc_d   = ifid_npc_q;
        ifid_valid_d = ifid_valid_q;
        req_en       = 1'b1;
        req_addr     = pc_addr;
        hold_pc      = 1'b1;

        unique case (state_q)
            FETCH: begin
                hold_pc = !(ihit && !stall) && !flush;
                if (flush) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                    // A miss is still in flight at the old address; park on it
                    // so the cache sees a stable request until it completes.
                    if (!ihit) begin
                        drain_addr_d = pc_addr;
                        state_d      = DRAIN;
                    end
                end else if (stall) begin
                    // Hold IF/ID; any hit this cycle is refetched later.
                end else if (ihit) begin
                    ifid_instr_d = imemload;
                    ifid_npc_d   = pc_addr + INSTR_BYTES;
                    ifid_valid_d = 1'b1;
                    if (imemload == HALT_WORD) begin
                        state_d = HALT;
                    end
                end else begin
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                end
            end

            DRAIN: begin
                req_addr = drain_addr_q;
                // Returned data belongs to the squashed path and is dropped.
                if (flush) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                end else if (ihit) begin
                    state_d = FETCH;
                end
            end

            HALT: begin
                req_en = 1'b0;
                // The halt may sit on a mispredicted path; a flush undoes it.
                if (flush) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= FETCH;
            drain_addr_q <= '0;
            ifid_instr_q <= NOP_WORD;
            ifid_npc_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q      <= state_d;
            drain_addr_q <= drain_addr_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_npc_q   <= ifid_npc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // While reset is held the PC is frozen and no cache request is made.
    assign imemREN    = req_en && nRST;
    assign pc_wait    = hold_pc || !nRST;
    assign imemaddr   = req_addr;
    assign halted     = (state_q == HALT);
    assign ifid_instr = ifid_instr_q;
    assign ifid_npc   = ifid_npc_q;
    assign ifid_valid = ifid_valid_q;

endmodule : fetch_unit
